// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, issues one imem request at a time and
// hands fetched instructions to decode through a stallable output register with a 1-entry skid.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        change_pc,
  input  logic [31:0] new_pc,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_skid;
  logic        r_imemReq;
  logic [31:0] r_imemAddr;
  logic        r_ifValid;
  logic [31:0] r_ifPc;
  logic [31:0] r_ifInstr;
  logic        r_misalign;

  logic [31:0] w_target;
  logic [31:0] w_pcNext;
  logic        w_slotFree;

  assign w_target   = {new_pc[31:2], 2'b00};
  assign w_pcNext   = r_pc + 32'd4;
  assign w_slotFree = !r_ifValid || !id_stall;

  // Redirect outranks everything; in REQ/DRAIN, imem_addr must not move until the pending ack arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_skid     <= 32'h0;
      r_imemReq  <= 1'b0;
      r_imemAddr <= 32'h0;
      r_ifValid  <= 1'b0;
      r_ifPc     <= 32'h0;
      r_ifInstr  <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (change_pc) begin
        r_pc       <= w_target;
        r_ifValid  <= 1'b0;
        r_misalign <= |new_pc[1:0];
        case (r_state)
          S_REQ, S_DRAIN: begin
            if (imem_ack) begin
              r_state    <= S_REQ;
              r_imemReq  <= 1'b1;
              r_imemAddr <= w_target;
            end else begin
              r_state <= S_DRAIN;
            end
          end
          default: begin
            r_state    <= S_REQ;
            r_imemReq  <= 1'b1;
            r_imemAddr <= w_target;
          end
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state    <= S_REQ;
            r_imemReq  <= 1'b1;
            r_imemAddr <= r_pc;
          end
          S_REQ: begin
            if (imem_ack && w_slotFree) begin
              r_ifInstr  <= imem_rdata;
              r_ifPc     <= r_pc;
              r_ifValid  <= 1'b1;
              r_pc       <= w_pcNext;
              r_imemAddr <= w_pcNext;
            end else if (imem_ack) begin
              r_skid    <= imem_rdata;
              r_imemReq <= 1'b0;
              r_state   <= S_HOLD;
            end else if (!id_stall) begin
              r_ifValid <= 1'b0;
            end
          end
          S_HOLD: begin
            if (!id_stall) begin
              r_ifInstr  <= r_skid;
              r_ifPc     <= r_pc;
              r_ifValid  <= 1'b1;
              r_pc       <= w_pcNext;
              r_imemReq  <= 1'b1;
              r_imemAddr <= w_pcNext;
              r_state    <= S_REQ;
            end
          end
          S_DRAIN: begin
            // Wrong-path data returned by this ack is dropped; restart at the redirect target.
            if (imem_ack) begin
              r_state    <= S_REQ;
              r_imemAddr <= r_pc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_req     = r_imemReq;
  assign imem_addr    = r_imemAddr;
  assign if_valid     = r_ifValid;
  assign if_pc        = r_ifPc;
  assign if_instr     = r_ifInstr;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: imem returns ~address as the instruction word.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        change_pc;
  logic [31:0] new_pc;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_err;

  int checkCount = 0;
  int errorCount = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .change_pc    (change_pc),
    .new_pc       (new_pc),
    .id_stall     (id_stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .misalign_err (misalign_err)
  );

  assign imem_rdata = ~imem_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sets inputs for the next rising edge, then waits to the following falling edge to observe.
  task automatic applyStimulus(input logic chg, input logic [31:0] tgt, input logic stall,
                               input logic ack);
    change_pc = chg;
    new_pc    = tgt;
    id_stall  = stall;
    imem_ack  = ack;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    change_pc = 1'b0;
    new_pc = 32'h0;
    id_stall = 1'b0;
    imem_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_req",      {31'h0, imem_req},     32'h0);
    checkOutput("rst_addr",     imem_addr,             32'h0);
    checkOutput("rst_valid",    {31'h0, if_valid},     32'h0);
    checkOutput("rst_pc",       if_pc,                 32'h0);
    checkOutput("rst_instr",    if_instr,              32'h0);
    checkOutput("rst_misalign", {31'h0, misalign_err}, 32'h0);

    // Sequential fetch at one instruction per cycle; ack during IDLE is ignored
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("idle_req",   {31'h0, imem_req}, 32'h1);
    checkOutput("idle_addr",  imem_addr,         32'h0000_0100);
    checkOutput("idle_valid", {31'h0, if_valid}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("seq0_pc",    if_pc,             32'h0000_0100);
    checkOutput("seq0_instr", if_instr,          ~32'h0000_0100);
    checkOutput("seq0_addr",  imem_addr,         32'h0000_0104);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("seq1_pc",    if_pc,             32'h0000_0104);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("seq2_pc",    if_pc,             32'h0000_0108);
    checkOutput("seq2_valid", {31'h0, if_valid}, 32'h1);

    // Redirect with same-cycle ack: acked data dropped
    applyStimulus(1'b1, 32'h0000_2000, 1'b0, 1'b1);
    checkOutput("redir_valid", {31'h0, if_valid},     32'h0);
    checkOutput("redir_addr",  imem_addr,             32'h0000_2000);
    checkOutput("redir_mis",   {31'h0, misalign_err}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("redir_pc",    if_pc,                 32'h0000_2000);
    checkOutput("redir_instr", if_instr,              ~32'h0000_2000);

    // Stall for three cycles with an ack arriving into the skid
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("stall0_pc",  if_pc,             32'h0000_2000);
    checkOutput("stall0_req", {31'h0, imem_req}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("stall1_valid", {31'h0, if_valid}, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("stall2_pc",  if_pc,             32'h0000_2000);
    checkOutput("stall2_req", {31'h0, imem_req}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("skid_pc",    if_pc,             32'h0000_2004);
    checkOutput("skid_instr", if_instr,          ~32'h0000_2004);
    checkOutput("skid_req",   {31'h0, imem_req}, 32'h1);
    checkOutput("skid_addr",  imem_addr,         32'h0000_2008);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("resume_pc",  if_pc,             32'h0000_2008);

    // Redirect while a request is pending, second redirect in DRAIN, ack three cycles later
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("consume_valid", {31'h0, if_valid}, 32'h0);
    applyStimulus(1'b1, 32'h0000_3000, 1'b0, 1'b0);
    checkOutput("drain0_addr", imem_addr,         32'h0000_200C);
    checkOutput("drain0_req",  {31'h0, imem_req}, 32'h1);
    applyStimulus(1'b1, 32'h0000_4000, 1'b0, 1'b0);
    checkOutput("drain1_addr", imem_addr,         32'h0000_200C);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("drain2_addr",  imem_addr,         32'h0000_200C);
    checkOutput("drain2_valid", {31'h0, if_valid}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("drained_addr",  imem_addr,         32'h0000_4000);
    checkOutput("drained_valid", {31'h0, if_valid}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("latest_pc", if_pc, 32'h0000_4000);

    // Misaligned redirect target
    applyStimulus(1'b1, 32'h0000_1003, 1'b0, 1'b1);
    checkOutput("mis_pulse", {31'h0, misalign_err}, 32'h1);
    checkOutput("mis_addr",  imem_addr,             32'h0000_1000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("mis_clear", {31'h0, misalign_err}, 32'h0);
    checkOutput("mis_pc",    if_pc,                 32'h0000_1000);

    // PC wrap at the top of the address space
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    checkOutput("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wrap_pc",    if_pc,     32'hFFFF_FFFC);
    checkOutput("wrap_addr1", imem_addr, 32'h0000_0000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wrap_pc0",    if_pc,    32'h0000_0000);
    checkOutput("wrap_instr0", if_instr, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of DRAIN, then a late ack after release
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_5000, 1'b0, 1'b0);
    checkOutput("pre_rst_req",  {31'h0, imem_req}, 32'h1);
    checkOutput("pre_rst_addr", imem_addr,         32'h0000_0004);
    change_pc = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_req",   {31'h0, imem_req}, 32'h0);
    checkOutput("async_addr",  imem_addr,         32'h0);
    checkOutput("async_instr", if_instr,          32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("late_ack_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("late_ack_addr",  imem_addr,         32'h0000_0100);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("restart_pc", if_pc, 32'h0000_0100);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
